// File: rtl/framebuffer_1bpp_if.sv
// Read, write and clear port bundle between the graphics writers / OLED driver and the
// 1bpp framebuffer.
interface framebuffer_1bpp_if;
  logic       fb_re;
  logic [7:0] fb_r_xpos;
  logic [7:0] fb_r_ypos;
  logic       fb_r_mode;
  logic [7:0] fb_dout;
  logic       fb_data_valid;
  logic       fb_busy;
  logic       fb_we;
  logic [7:0] fb_w_xpos;
  logic [7:0] fb_w_ypos;
  logic       fb_w_pixel;
  logic       fb_clear;

  modport master (
    output fb_re, fb_r_xpos, fb_r_ypos, fb_r_mode,
    output fb_we, fb_w_xpos, fb_w_ypos, fb_w_pixel, fb_clear,
    input  fb_dout, fb_data_valid, fb_busy
  );

  modport slave (
    input  fb_re, fb_r_xpos, fb_r_ypos, fb_r_mode,
    input  fb_we, fb_w_xpos, fb_w_ypos, fb_w_pixel, fb_clear,
    output fb_dout, fb_data_valid, fb_busy
  );
endinterface

// File: rtl/framebuffer_1bpp.sv
// Page-major 1bpp framebuffer: column/horizontal 8-pixel reads, read-modify-write pixel
// writes and a sequential full clear, all sharing one synchronous single-port RAM.
module framebuffer_1bpp #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned HEIGHT = 64
) (
  input logic               clk,
  input logic               reset,
  framebuffer_1bpp_if.slave fb
);

  localparam int unsigned Depth = WIDTH * HEIGHT / 8;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [8:0]  WidthL = 9'(WIDTH);
  localparam logic [8:0]  HeightL = 9'(HEIGHT);
  localparam logic [10:0] WidthA = 11'(WIDTH);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdFetch,
    StRdHold,
    StWrRd,
    StWrWait,
    StWrWr,
    StClearing
  } state_e;

  // Returns {in_range, byte_address} for access k of a read (or k=0 column for a write).
  // Coordinates widen to 9 bits so x+k / page+1 overflow is seen instead of wrapping.
  function automatic logic [11:0] lookup(input logic col, input logic [7:0] x,
                                         input logic [7:0] y, input logic [3:0] k);
    logic [8:0]  xx;
    logic [8:0]  yy;
    logic        ok;
    logic [10:0] addr;
    if (col) begin
      xx = {1'b0, x};
      yy = {1'b0, y[7:3], 3'b000} + {2'b00, k, 3'b000};
    end else begin
      xx = {1'b0, x} + {5'b00000, k};
      yy = {1'b0, y};
    end
    ok   = (xx < WidthL) && (yy < HeightL);
    addr = {5'b00000, yy[8:3]} * WidthA + {2'b00, xx};
    return {ok, addr};
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       ry_q, ry_d;
  logic             rmode_q, rmode_d;
  logic [3:0]       n_q, n_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             clr_pend_q, clr_pend_d;
  logic [AddrW-1:0] clr_q, clr_d;
  logic [10:0]      w_addr_q, w_addr_d;
  logic [2:0]       w_bit_q, w_bit_d;
  logic             w_pix_q, w_pix_d;
  logic             w_ok_q, w_ok_d;
  logic             rd_en_q;

  logic             ram_re;
  logic             ram_we;
  logic [10:0]      ram_addr;
  logic [7:0]       ram_wdata;
  logic [7:0]       ram_q;
  logic [7:0]       mem [Depth];
  logic [AddrW-1:0] ram_idx;
  logic [10-AddrW:0] unused_addr_hi;

  logic [11:0] cap_lu;
  logic [11:0] fetch_lu;
  logic [11:0] wr_lu;
  logic [7:0]  byte_in;
  logic [15:0] merged;
  logic        hbit;

  assign cap_lu   = lookup(fb.fb_r_mode, fb.fb_r_xpos, fb.fb_r_ypos, 4'd0);
  assign fetch_lu = lookup(rmode_q, rx_q, ry_q, cnt_q);
  assign wr_lu    = lookup(1'b1, fb.fb_w_xpos, fb.fb_w_ypos, 4'd0);

  // Suppressed (out-of-range) reads contribute zero bytes.
  assign byte_in = rd_en_q ? ram_q : 8'h00;
  assign merged  = {byte_in, acc_q} >> ry_q[2:0];
  assign hbit    = byte_in[ry_q[2:0]];

  assign ram_idx        = ram_addr[AddrW-1:0];
  assign unused_addr_hi = ram_addr[10:AddrW];

  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      mem[ram_idx] <= ram_wdata;
    end
    if (ram_re) begin
      ram_q <= mem[ram_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    rmode_d    = rmode_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    clr_pend_d = clr_pend_q;
    clr_d      = clr_q;
    w_addr_d   = w_addr_q;
    w_bit_d    = w_bit_q;
    w_pix_d    = w_pix_q;
    w_ok_d     = w_ok_q;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = 11'd0;
    ram_wdata  = 8'h00;

    if (state_q != StIdle && fb.fb_clear) begin
      clr_pend_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (clr_pend_q || fb.fb_clear) begin
          clr_pend_d = 1'b0;
          clr_d      = '0;
          state_d    = StClearing;
        end else if (fb.fb_we) begin
          w_addr_d = wr_lu[10:0];
          w_bit_d  = fb.fb_w_ypos[2:0];
          w_pix_d  = fb.fb_w_pixel;
          w_ok_d   = wr_lu[11];
          // Out-of-range writes spend one cycle in StWrWr with the RAM write masked.
          state_d  = wr_lu[11] ? StWrRd : StWrWr;
        end else if (fb.fb_re) begin
          rx_d     = fb.fb_r_xpos;
          ry_d     = fb.fb_r_ypos;
          rmode_d  = fb.fb_r_mode;
          n_d      = !fb.fb_r_mode ? 4'd8 : (fb.fb_r_ypos[2:0] == 3'd0 ? 4'd1 : 4'd2);
          cnt_d    = 4'd1;
          acc_d    = 8'h00;
          // First access goes out in the capture cycle to reach an N+1 latency.
          ram_re   = cap_lu[11];
          ram_addr = cap_lu[10:0];
          state_d  = StRdFetch;
        end
      end
      StRdFetch: begin
        if (!fb.fb_re) begin
          state_d = StIdle;
        end else if (cnt_q == n_q) begin
          if (!rmode_q) begin
            dout_d = {acc_q[6:0], hbit};
          end else begin
            dout_d = (n_q == 4'd1) ? byte_in : merged[7:0];
          end
          valid_d = 1'b1;
          state_d = StRdHold;
        end else begin
          acc_d    = rmode_q ? byte_in : {acc_q[6:0], hbit};
          ram_re   = fetch_lu[11];
          ram_addr = fetch_lu[10:0];
          cnt_d    = cnt_q + 4'd1;
        end
      end
      StRdHold: begin
        if (!fb.fb_re) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      StWrRd: begin
        ram_re   = 1'b1;
        ram_addr = w_addr_q;
        state_d  = StWrWait;
      end
      StWrWait: begin
        state_d = StWrWr;
      end
      StWrWr: begin
        ram_we             = w_ok_q;
        ram_addr           = w_addr_q;
        ram_wdata          = ram_q;
        ram_wdata[w_bit_q] = w_pix_q;
        state_d            = StIdle;
      end
      StClearing: begin
        ram_we   = 1'b1;
        ram_addr = 11'(clr_q);
        clr_d    = clr_q + AddrW'(1);
        if (clr_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rx_q       <= 8'd0;
      ry_q       <= 8'd0;
      rmode_q    <= 1'b0;
      n_q        <= 4'd0;
      cnt_q      <= 4'd0;
      acc_q      <= 8'h00;
      dout_q     <= 8'h00;
      valid_q    <= 1'b0;
      clr_pend_q <= 1'b0;
      clr_q      <= '0;
      w_addr_q   <= 11'd0;
      w_bit_q    <= 3'd0;
      w_pix_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      rmode_q    <= rmode_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      clr_pend_q <= clr_pend_d;
      clr_q      <= clr_d;
      w_addr_q   <= w_addr_d;
      w_bit_q    <= w_bit_d;
      w_pix_q    <= w_pix_d;
      w_ok_q     <= w_ok_d;
      rd_en_q    <= ram_re;
    end
  end

  assign fb.fb_dout       = dout_q;
  assign fb.fb_data_valid = valid_q;
  assign fb.fb_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_framebuffer_1bpp.sv
// Directed bench for framebuffer_1bpp with a pixel-array reference model.
module tb_framebuffer_1bpp;
  localparam int W = 128;
  localparam int H = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  framebuffer_1bpp_if fb();

  framebuffer_1bpp #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk  (clk),
    .reset(reset),
    .fb   (fb)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  bit         pix [W][H];
  logic [7:0] exp_dout = 8'h00;
  bit         exp_armed = 1'b0;

  function automatic bit px(input int x, input int y);
    if (x < W && y < H) return pix[x][y];
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_read(input int x, input int y, input bit col);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (col) r[k] = px(x, y + k);
      else     r[7-k] = px(x + k, y);
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) pix[x][y] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Whenever valid is up, the output must match the model for the outstanding request.
  always @(negedge clk) begin
    if (!reset && fb.fb_data_valid) begin
      if (!exp_armed) check("valid_unrequested", 32'(fb.fb_data_valid), 32'd0);
      else            check("dout_vs_model", 32'(fb.fb_dout), 32'(exp_dout));
    end
  end

  task automatic wr(input int x, input int y, input bit p, input int exp_busy);
    int n;
    @(negedge clk);
    fb.fb_we = 1'b1;
    fb.fb_w_xpos = 8'(x);
    fb.fb_w_ypos = 8'(y);
    fb.fb_w_pixel = p;
    @(negedge clk);
    fb.fb_we = 1'b0;
    if (x < W && y < H) pix[x][y] = p;
    n = 0;
    while (fb.fb_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("wr_busy_cycles", 32'(n), 32'(exp_busy));
  endtask

  task automatic rd(input int x, input int y, input bit col, input int exp_lat, input bit poke,
                    output logic [7:0] d);
    int k;
    @(negedge clk);
    exp_dout = model_read(x, y, col);
    exp_armed = 1'b1;
    fb.fb_re = 1'b1;
    fb.fb_r_xpos = 8'(x);
    fb.fb_r_ypos = 8'(y);
    fb.fb_r_mode = col;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      // Request fields only matter in the capture cycle.
      fb.fb_r_xpos = ~8'(x);
      fb.fb_r_ypos = 8'(y + 3);
      fb.fb_r_mode = ~col;
    end while (!fb.fb_data_valid && k < 40);
    check("rd_latency", 32'(k), 32'(exp_lat));
    d = fb.fb_dout;
    if (poke) begin
      fb.fb_we = 1'b1;
      fb.fb_w_xpos = 8'(x);
      fb.fb_w_ypos = 8'(y);
      fb.fb_w_pixel = 1'b1;
    end
    @(negedge clk);
    fb.fb_we = 1'b0;
    check("rd_hold_valid", 32'(fb.fb_data_valid), 32'd1);
    check("rd_hold_dout", 32'(fb.fb_dout), 32'(d));
    fb.fb_re = 1'b0;
    @(negedge clk);
    check("rd_release_valid", 32'(fb.fb_data_valid), 32'd0);
    exp_armed = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (fb.fb_busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int         n;
    int         k;
    int         seen;

    fb.fb_re = 1'b0;
    fb.fb_r_xpos = 8'd0;
    fb.fb_r_ypos = 8'd0;
    fb.fb_r_mode = 1'b0;
    fb.fb_we = 1'b0;
    fb.fb_w_xpos = 8'd0;
    fb.fb_w_ypos = 8'd0;
    fb.fb_w_pixel = 1'b0;
    fb.fb_clear = 1'b0;
    model_clear();

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(fb.fb_busy), 32'd0);
    check("reset_valid", 32'(fb.fb_data_valid), 32'd0);
    check("reset_dout", 32'(fb.fb_dout), 32'd0);
    reset = 1'b0;

    // Clear, then aligned column read.
    @(negedge clk);
    fb.fb_clear = 1'b1;
    @(negedge clk);
    fb.fb_clear = 1'b0;
    count_busy(n);
    check("clear_cycles", 32'(n), 32'd1024);
    model_clear();
    wr(5, 10, 1'b1, 3);
    rd(5, 8, 1'b1, 2, 1'b0, d);
    check("col_aligned", 32'(d), 32'h04);

    // Unaligned column reads, including the bottom edge.
    rd(5, 6, 1'b1, 3, 1'b0, d);
    check("col_unaligned", 32'(d), 32'h10);
    wr(5, 61, 1'b1, 3);
    rd(5, 60, 1'b1, 3, 1'b0, d);
    check("col_bottom_edge", 32'(d), 32'h02);

    // Horizontal reads, right edge, out-of-range writes.
    wr(0, 3, 1'b1, 3);
    wr(7, 3, 1'b1, 3);
    wr(124, 3, 1'b1, 3);
    wr(127, 3, 1'b1, 3);
    wr(200, 3, 1'b1, 1);
    wr(5, 70, 1'b1, 1);
    rd(0, 3, 1'b0, 9, 1'b0, d);
    check("horiz_left", 32'(d), 32'h81);
    rd(124, 3, 1'b0, 9, 1'b0, d);
    check("horiz_right_edge", 32'(d), 32'h90);
    rd(120, 3, 1'b0, 9, 1'b0, d);
    check("horiz_120", 32'(d), 32'h09);
    wr(127, 3, 1'b0, 3);
    rd(124, 3, 1'b0, 9, 1'b0, d);
    check("horiz_after_unset", 32'(d), 32'h80);

    // Clear arriving mid-read waits for the read to finish.
    @(negedge clk);
    exp_dout = model_read(5, 6, 1'b1);
    exp_armed = 1'b1;
    fb.fb_re = 1'b1;
    fb.fb_r_xpos = 8'd5;
    fb.fb_r_ypos = 8'd6;
    fb.fb_r_mode = 1'b1;
    @(negedge clk);
    fb.fb_clear = 1'b1;
    @(negedge clk);
    fb.fb_clear = 1'b0;
    k = 0;
    while (!fb.fb_data_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("read_before_clear", 32'(fb.fb_dout), 32'h10);
    fb.fb_re = 1'b0;
    @(negedge clk);
    exp_armed = 1'b0;
    k = 0;
    while (fb.fb_busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!fb.fb_busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    count_busy(n);
    check("pending_clear_cycles", 32'(n), 32'd1024);
    model_clear();
    rd(5, 8, 1'b1, 2, 1'b0, d);
    check("cleared_col_5_8", 32'(d), 32'h00);
    rd(5, 60, 1'b1, 3, 1'b0, d);
    check("cleared_col_5_60", 32'(d), 32'h00);
    rd(0, 3, 1'b0, 9, 1'b0, d);
    check("cleared_horiz_0_3", 32'(d), 32'h00);

    // Reset during CLEARING and RD_FETCH; RAM outside the partial clear is retained.
    wr(5, 10, 1'b1, 3);
    rd(5, 8, 1'b1, 2, 1'b0, d);
    @(negedge clk);
    fb.fb_clear = 1'b1;
    @(negedge clk);
    fb.fb_clear = 1'b0;
    repeat (10) @(negedge clk);
    check("clearing_busy", 32'(fb.fb_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_clear_busy", 32'(fb.fb_busy), 32'd0);
    check("rst_clear_valid", 32'(fb.fb_data_valid), 32'd0);
    check("rst_clear_dout", 32'(fb.fb_dout), 32'd0);
    reset = 1'b0;
    rd(5, 8, 1'b1, 2, 1'b0, d);
    check("retained_after_reset", 32'(d), 32'h04);
    @(negedge clk);
    fb.fb_re = 1'b1;
    fb.fb_r_xpos = 8'd0;
    fb.fb_r_ypos = 8'd10;
    fb.fb_r_mode = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    fb.fb_re = 1'b0;
    @(negedge clk);
    check("rst_fetch_busy", 32'(fb.fb_busy), 32'd0);
    check("rst_fetch_valid", 32'(fb.fb_data_valid), 32'd0);
    check("rst_fetch_dout", 32'(fb.fb_dout), 32'd0);
    reset = 1'b0;
    rd(40, 40, 1'b1, 2, 1'b1, d);
    rd(40, 40, 1'b1, 2, 1'b0, d);
    check("we_while_busy_dropped", 32'(d), 32'h00);

    // Abort a horizontal read one cycle after capture.
    @(negedge clk);
    fb.fb_re = 1'b1;
    fb.fb_r_xpos = 8'd0;
    fb.fb_r_ypos = 8'd0;
    fb.fb_r_mode = 1'b0;
    @(negedge clk);
    fb.fb_re = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(fb.fb_busy), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (fb.fb_data_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    // Simultaneous write and read: write wins, read sees the new pixel.
    @(negedge clk);
    fb.fb_we = 1'b1;
    fb.fb_w_xpos = 8'd30;
    fb.fb_w_ypos = 8'd30;
    fb.fb_w_pixel = 1'b1;
    fb.fb_re = 1'b1;
    fb.fb_r_xpos = 8'd30;
    fb.fb_r_ypos = 8'd24;
    fb.fb_r_mode = 1'b1;
    pix[30][30] = 1'b1;
    exp_dout = model_read(30, 24, 1'b1);
    exp_armed = 1'b1;
    @(negedge clk);
    fb.fb_we = 1'b0;
    k = 1;
    while (!fb.fb_data_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("simul_latency", 32'(k), 32'd6);
    check("simul_dout", 32'(fb.fb_dout), 32'h40);
    fb.fb_re = 1'b0;
    @(negedge clk);
    exp_armed = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
